// File: rtl/de_pipe_reg.sv
// Decode/Execute pipeline register: captures Decode outputs each edge, applies
// late M/W forwarding to rs/rt, injects bubbles on stall/flush and counts them.
module de_pipe_reg #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic [31:0]       D_PC,
    input  logic [31:0]       D_instruction,
    input  logic [31:0]       D_data_rs,
    input  logic [31:0]       D_data_rt,
    input  logic [31:0]       D_addr_rt,
    input  logic [31:0]       D_addr_rd,
    input  logic [31:0]       D_EXT,
    input  logic [31:0]       D_Shift,
    input  logic [4:0]        M_RegWreg,
    input  logic [31:0]       M_RegWD,
    input  logic              M_RegWrite,
    input  logic [4:0]        W_RegWreg,
    input  logic [31:0]       W_RegWD,
    input  logic              W_RegWrite,
    output logic [31:0]       E_PC,
    output logic [31:0]       E_instruction,
    output logic [31:0]       E_data_rs,
    output logic [31:0]       E_data_rt,
    output logic [31:0]       E_addr_rt,
    output logic [31:0]       E_addr_rd,
    output logic [31:0]       E_EXT,
    output logic [31:0]       E_Shift,
    output logic              E_valid,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned RIDX_W = 5;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] data_rs;
        logic [XLEN-1:0] data_rt;
        logic [XLEN-1:0] addr_rt;
        logic [XLEN-1:0] addr_rd;
        logic [XLEN-1:0] ext;
        logic [XLEN-1:0] shift;
    } e_payload_t;

    logic [RIDX_W-1:0] w_rs_idx;
    logic [RIDX_W-1:0] w_rt_idx;
    logic [XLEN-1:0]   w_fwd_rs;
    logic [XLEN-1:0]   w_fwd_rt;
    logic              w_bubble;
    logic              w_cnt_sat;
    e_payload_t        w_next;
    e_payload_t        r_e;
    logic              r_valid;
    logic [CNT_W-1:0]  r_bubble_cnt;

    assign w_rs_idx  = D_instruction[25:21];
    assign w_rt_idx  = D_instruction[20:16];
    assign w_bubble  = stall | flush;
    assign w_cnt_sat = &r_bubble_cnt;

    // Late forwarding: M beats W, and $0 never forwards.
    always_comb begin
        w_fwd_rs = D_data_rs;
        if (M_RegWrite && (M_RegWreg == w_rs_idx) && (w_rs_idx != '0)) begin
            w_fwd_rs = M_RegWD;
        end else if (W_RegWrite && (W_RegWreg == w_rs_idx) && (w_rs_idx != '0)) begin
            w_fwd_rs = W_RegWD;
        end
    end

    always_comb begin
        w_fwd_rt = D_data_rt;
        if (M_RegWrite && (M_RegWreg == w_rt_idx) && (w_rt_idx != '0)) begin
            w_fwd_rt = M_RegWD;
        end else if (W_RegWrite && (W_RegWreg == w_rt_idx) && (w_rt_idx != '0)) begin
            w_fwd_rt = W_RegWD;
        end
    end

    // Bubble keeps the PC for traceability and zeroes everything else.
    always_comb begin
        w_next.pc      = D_PC;
        w_next.instr   = D_instruction;
        w_next.data_rs = w_fwd_rs;
        w_next.data_rt = w_fwd_rt;
        w_next.addr_rt = D_addr_rt;
        w_next.addr_rd = D_addr_rd;
        w_next.ext     = D_EXT;
        w_next.shift   = D_Shift;
        if (w_bubble) begin
            w_next.instr   = NOP_INSTR;
            w_next.data_rs = '0;
            w_next.data_rt = '0;
            w_next.addr_rt = '0;
            w_next.addr_rd = '0;
            w_next.ext     = '0;
            w_next.shift   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_e.pc       <= '0;
            r_e.instr    <= NOP_INSTR;
            r_e.data_rs  <= '0;
            r_e.data_rt  <= '0;
            r_e.addr_rt  <= '0;
            r_e.addr_rd  <= '0;
            r_e.ext      <= '0;
            r_e.shift    <= '0;
            r_valid      <= 1'b0;
            r_bubble_cnt <= '0;
        end else begin
            r_e     <= w_next;
            r_valid <= ~w_bubble;
            if (w_bubble && !w_cnt_sat) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
        end
    end

    assign E_PC          = r_e.pc;
    assign E_instruction = r_e.instr;
    assign E_data_rs     = r_e.data_rs;
    assign E_data_rt     = r_e.data_rt;
    assign E_addr_rt     = r_e.addr_rt;
    assign E_addr_rd     = r_e.addr_rd;
    assign E_EXT         = r_e.ext;
    assign E_Shift       = r_e.shift;
    assign E_valid       = r_valid;
    assign bubble_cnt    = r_bubble_cnt;

endmodule

// File: tb/tb_de_pipe_reg.sv
// Scoreboard bench for de_pipe_reg: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them once the capture edge has passed.
module tb_de_pipe_reg;

    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, stall, flush;
    logic [31:0]   D_PC, D_instruction, D_data_rs, D_data_rt;
    logic [31:0]   D_addr_rt, D_addr_rd, D_EXT, D_Shift;
    logic [4:0]    M_RegWreg, W_RegWreg;
    logic [31:0]   M_RegWD, W_RegWD;
    logic          M_RegWrite, W_RegWrite;
    logic [31:0]   E_PC, E_instruction, E_data_rs, E_data_rt;
    logic [31:0]   E_addr_rt, E_addr_rd, E_EXT, E_Shift;
    logic          E_valid;
    logic [CW-1:0] bubble_cnt;

    de_pipe_reg #(.NOP_INSTR(32'h0000_0000), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .D_PC(D_PC), .D_instruction(D_instruction),
        .D_data_rs(D_data_rs), .D_data_rt(D_data_rt),
        .D_addr_rt(D_addr_rt), .D_addr_rd(D_addr_rd),
        .D_EXT(D_EXT), .D_Shift(D_Shift),
        .M_RegWreg(M_RegWreg), .M_RegWD(M_RegWD), .M_RegWrite(M_RegWrite),
        .W_RegWreg(W_RegWreg), .W_RegWD(W_RegWD), .W_RegWrite(W_RegWrite),
        .E_PC(E_PC), .E_instruction(E_instruction),
        .E_data_rs(E_data_rs), .E_data_rt(E_data_rt),
        .E_addr_rt(E_addr_rt), .E_addr_rd(E_addr_rd),
        .E_EXT(E_EXT), .E_Shift(E_Shift),
        .E_valid(E_valid), .bubble_cnt(bubble_cnt)
    );

    typedef struct {
        logic [31:0]   pc, instr, rs, rt, art, ard, ext, sh;
        logic          valid;
        logic [CW-1:0] cnt;
        int unsigned   due;
    } exp_t;

    exp_t          q[$];
    int unsigned   cyc = 0;
    int            errors = 0;
    int            checks = 0;
    logic [CW-1:0] exp_cnt;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: compare every expectation whose capture edge has passed.
    always @(negedge clk) begin : monitor
        exp_t e;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            chk("due_cycle", cyc, e.due);
            chk("E_PC", E_PC, e.pc);
            chk("E_instruction", E_instruction, e.instr);
            chk("E_data_rs", E_data_rs, e.rs);
            chk("E_data_rt", E_data_rt, e.rt);
            chk("E_addr_rt", E_addr_rt, e.art);
            chk("E_addr_rd", E_addr_rd, e.ard);
            chk("E_EXT", E_EXT, e.ext);
            chk("E_Shift", E_Shift, e.sh);
            chk("E_valid", {31'b0, E_valid}, {31'b0, e.valid});
            chk("bubble_cnt", {28'b0, bubble_cnt}, {28'b0, e.cnt});
        end
    end

    task automatic set_d(input logic [31:0] pc, instr, rs, rt, art, ard, ext, sh);
        D_PC = pc; D_instruction = instr; D_data_rs = rs; D_data_rt = rt;
        D_addr_rt = art; D_addr_rd = ard; D_EXT = ext; D_Shift = sh;
    endtask

    task automatic set_fwd(input logic [4:0] mreg, input logic [31:0] mwd, input logic mwe,
                           input logic [4:0] wreg, input logic [31:0] wwd, input logic wwe);
        M_RegWreg = mreg; M_RegWD = mwd; M_RegWrite = mwe;
        W_RegWreg = wreg; W_RegWD = wwd; W_RegWrite = wwe;
    endtask

    // Queue the expectation for the coming edge, then advance past it.
    task automatic step(input logic [31:0] ers, input logic [31:0] ert);
        exp_t e;
        logic bub;
        bub = stall | flush;
        if (bub && exp_cnt != {CW{1'b1}}) exp_cnt = exp_cnt + CW'(1);
        e.pc    = D_PC;
        e.instr = bub ? 32'h0 : D_instruction;
        e.rs    = bub ? 32'h0 : ers;
        e.rt    = bub ? 32'h0 : ert;
        e.art   = bub ? 32'h0 : D_addr_rt;
        e.ard   = bub ? 32'h0 : D_addr_rd;
        e.ext   = bub ? 32'h0 : D_EXT;
        e.sh    = bub ? 32'h0 : D_Shift;
        e.valid = !bub;
        e.cnt   = exp_cnt;
        e.due   = cyc + 1;
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        for (int i = 0; i < 10; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0; exp_cnt = '0;
        set_d(0, 0, 0, 0, 0, 0, 0, 0);
        set_fwd(0, 0, 1'b0, 0, 0, 1'b0);
        #12;
        chk("rst_E_PC", E_PC, 0);
        chk("rst_E_instruction", E_instruction, 0);
        chk("rst_E_data_rs", E_data_rs, 0);
        chk("rst_E_data_rt", E_data_rt, 0);
        chk("rst_E_Shift", E_Shift, 0);
        chk("rst_E_valid", {31'b0, E_valid}, 0);
        chk("rst_bubble_cnt", {28'b0, bubble_cnt}, 0);

        @(posedge clk); #2;
        reset = 1'b1;
        // lui $1,0x1234: rs idx 0, rt idx 1, no forwarding enabled
        set_d(32'h3000, 32'h3C01_1234, 32'h11, 32'h22, 32'h1, 32'h0, 32'h1234, 32'h1234_0000);
        step(32'h11, 32'h22);

        // addu $3,$1,$2 stalled three times, then flush, then stall+flush
        set_d(32'h3004, 32'h0022_1821, 32'h0101, 32'h0202, 32'h2, 32'h3, 32'h1821, 32'h1821_0000);
        stall = 1'b1;
        step(0, 0); step(0, 0); step(0, 0);
        stall = 1'b0; flush = 1'b1;
        step(0, 0);
        stall = 1'b1;
        set_fwd(1, 32'hAAAA_0000, 1'b1, 2, 32'h5555_0000, 1'b1);
        step(0, 0);
        stall = 1'b0; flush = 1'b0;

        D_data_rt = 32'h0BAD_0002;
        set_fwd(1, 32'hAAAA_0000, 1'b1, 1, 32'h5555_0000, 1'b1);
        step(32'hAAAA_0000, 32'h0BAD_0002);
        set_fwd(1, 32'hAAAA_0000, 1'b0, 1, 32'h5555_0000, 1'b1);
        step(32'h5555_0000, 32'h0BAD_0002);
        set_fwd(2, 32'hCAFE_0002, 1'b1, 2, 32'hBEEF_0002, 1'b1);
        step(32'h0101, 32'hCAFE_0002);
        set_fwd(7, 32'hCAFE_0002, 1'b0, 2, 32'hBEEF_0002, 1'b1);
        step(32'h0101, 32'hBEEF_0002);

        // rs=rt=$0 with both buses targeting $0
        set_d(32'h3008, 32'h0000_1021, 32'h77, 32'h0, 32'h0, 32'h2, 32'h1021, 32'h0);
        set_fwd(0, 32'hFFFF_FFFF, 1'b1, 0, 32'h1234_5678, 1'b1);
        step(32'h77, 32'h0);

        drain();
        #2;
        chk("pre_rst_E_valid", {31'b0, E_valid}, 1);
        chk("pre_rst_bubble_cnt", {28'b0, bubble_cnt}, 5);
        reset = 1'b0;
        #1;
        chk("async_rst_E_valid", {31'b0, E_valid}, 0);
        chk("async_rst_bubble_cnt", {28'b0, bubble_cnt}, 0);
        chk("async_rst_E_instruction", E_instruction, 0);
        chk("async_rst_E_PC", E_PC, 0);
        chk("async_rst_E_data_rs", E_data_rs, 0);
        exp_cnt = '0;

        @(posedge clk); #2;
        reset = 1'b1;
        set_d(32'h4000, 32'h0022_1821, 32'h5, 32'h6, 32'h2, 32'h3, 32'h9, 32'h9);
        set_fwd(0, 0, 1'b0, 0, 0, 1'b0);
        stall = 1'b1;
        for (int i = 0; i < 20; i++) step(0, 0);
        stall = 1'b0;
        step(32'h5, 32'h6);
        drain();
        chk("sat_final_cnt", {28'b0, bubble_cnt}, 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/de_pipe_reg.md
Name: de_pipe_reg

Overview:
- Decode/Execute pipeline register that writes every operand the Execute stage reads, driving it on the E side each cycle.
- Captures Decode-stage outputs on each clock edge.
- On a Decode stall it inserts a bubble (nop), so Execute never sees a half-stalled instruction.
- Before latching rs/rt it applies late forwarding from the M/W write-back buses, and it keeps a saturating bubble counter for performance debug.

Parameters:
- NOP_INSTR, 32'h0000_0000, instruction word injected as a bubble (sll $0,$0,0).
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- stall  input  1  Decode stall from hazard unit; 1 = insert a bubble this edge.
- flush  input  1  clear E stage (branch-likely/exception); same register effect as stall.
- D_PC  input  32  PC of the Decode instruction.
- D_instruction  input  32  Decode instruction word.
- D_data_rs  input  32  GRF read data for rs.
- D_data_rt  input  32  GRF read data for rt.
- D_addr_rt  input  32  rt index, zero-extended; bits [4:0] significant.
- D_addr_rd  input  32  rd index, zero-extended; bits [4:0] significant.
- D_EXT  input  32  extended immediate.
- D_Shift  input  32  lui shift result.
- M_RegWreg  input  5  M-stage destination register.
- M_RegWD  input  32  M-stage write data.
- M_RegWrite  input  1  M-stage write enable.
- W_RegWreg  input  5  W-stage destination register.
- W_RegWD  input  32  W-stage write data.
- W_RegWrite  input  1  W-stage write enable.
- E_PC  output  32  registered PC to Execute.
- E_instruction  output  32  registered instruction to Execute.
- E_data_rs  output  32  registered, forwarded rs data.
- E_data_rt  output  32  registered, forwarded rt data.
- E_addr_rt  output  32  registered rt index.
- E_addr_rd  output  32  registered rd index.
- E_EXT  output  32  registered extended immediate.
- E_Shift  output  32  registered lui result.
- E_valid  output  1  1 = E holds a real instruction; 0 = bubble or reset.
- bubble_cnt  output  CNT_W  number of bubbles inserted since reset, saturating.

Behaviour:
- Reset (reset=0, asynchronous):
  - all E_* data outputs go to 0, E_instruction=NOP_INSTR, E_valid=0, bubble_cnt=0.
  - The reset takes effect immediately, mid-cycle included.
  - The first capture happens on the first rising edge after reset is released.
- Latency: exactly 1 cycle from D_* inputs to E_* outputs. There is no hold mode, because Execute never stalls.
- Normal edge (stall=0, flush=0): every E_* output takes its D_* input (rs/rt after forwarding) and E_valid=1.
- Bubble edge (stall=1 or flush=1):
  - E_instruction=NOP_INSTR.
  - E_data_rs, E_data_rt, E_addr_rt, E_addr_rd, E_EXT and E_Shift all go to 0.
  - E_PC=D_PC, kept for debug traceability.
  - E_valid=0.
  - stall=1 together with flush=1 counts as a single bubble.
- bubble_cnt:
  - increments by 1 on each bubble edge while reset is inactive.
  - saturates at all-ones and does not wrap.
- Forwarding at capture (rs index = D_instruction[25:21], rt index = D_instruction[20:16]):
  - Take M_RegWD if M_RegWrite=1, M_RegWreg==index and index!=0.
  - Otherwise take W_RegWD under the same conditions on the W bus.
  - Otherwise take D_data_*.
  - M has priority over W when both match. Index 0 always yields D_data_* (no forward to $0).
- Forwarding is ignored on bubble edges, since the data is zeroed anyway.
- No combinational path from any input to any output; every output is a flop.

Test Plan:
- Reset release then one normal edge:
  - with reset=0, all outputs read 0, E_instruction=0 and bubble_cnt=0.
  - release reset and apply D_PC=32'h3000, D_instruction=32'h3C01_1234 (lui), D_Shift=32'h1234_0000.
  - after 1 edge: E_PC=3000, E_Shift=12340000, E_valid=1.
- Stall bubble: stall=1 with D_instruction=32'h0022_1821 -> E_instruction=0, E_data_rs=0, E_valid=0, bubble_cnt=1; three consecutive stalls -> bubble_cnt=3.
- Forward priority:
  - rs=$1 with M_RegWreg=1, M_RegWD=AAAA_0000, W_RegWreg=1, W_RegWD=5555_0000, both enables set -> E_data_rs=AAAA0000.
  - same stimulus with M_RegWrite=0 -> E_data_rs=55550000.
- $0 guard: rt=$0, M_RegWreg=0, M_RegWrite=1, M_RegWD=FFFF_FFFF, D_data_rt=0 -> E_data_rt=0.
- Reset mid-operation:
  - assert reset between edges while E_valid=1 and bubble_cnt=5.
  - outputs clear immediately, without waiting for an edge: E_valid=0, bubble_cnt=0.
- Saturation: CNT_W=4, hold stall=1 for 20 edges -> bubble_cnt=15 and stays at 15.
